// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and constants for the load/store access unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } mau_state_t;

  localparam logic [3:0]  BE_WORD  = 4'hF;
  localparam logic [31:0] ERR_DATA = 32'h0;

  // Loads and stores at once, or an unaligned word access, never reach the bus.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic byte_acc, input logic [1:0] addr_lo);
    return (rd & wr) | (~byte_acc & (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_steer.sv
// ============================================================================
// mem_lane_steer : byte-lane enables, store replication and load extraction
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_steer
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        byte_acc,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  always_comb begin
    be        = BE_WORD;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    if (byte_acc) begin
      be        = 4'b0001 << addr_lo;
      wdata_out = {4{wdata_in[7:0]}};
      rdata_out = {24'b0, rdata_in[{addr_lo, 3'b000} +: 8]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : load/store stage driving a req/gnt/rvalid data bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteAcc,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        access;
  logic        timed_out;

  assign access    = MemRead | MemWrite;
  assign timed_out = (cnt_q == CNT_LAST);

  mem_lane_steer u_lane_steer (
    .addr_lo   (addr_q[1:0]),
    .byte_acc  (byte_q),
    .wdata_in  (wdata_q),
    .rdata_in  (bus_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (is_illegal(MemRead, MemWrite, ByteAcc, ALUResult[1:0])) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end else begin
            state_d = REQ;
            addr_d  = ALUResult;
            wdata_d = WriteData;
            we_d    = MemWrite;
            byte_d  = ByteAcc;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (bus_rvalid) begin
            state_d = DONE;
            rdata_d = lane_rdata;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = lane_rdata;
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end
      end
      default: state_d = IDLE;  // DONE lasts one cycle; strobes still high belong to the finished access
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    if (state_q == REQ) begin
      bus_req   = 1'b1;
      bus_we    = we_q;
      bus_addr  = {addr_q[31:2], 2'b00};
      bus_be    = lane_be;
      bus_wdata = we_q ? lane_wdata : '0;
    end
    // The detect-cycle hold is gated by reset so every output is quiet while reset is asserted.
    Stall    = ((state_q == IDLE) & access & reset) | (state_q == REQ) | (state_q == WAIT_RD);
    BusErr   = (state_q == DONE) & err_q;
    ReadData = rdata_q;
  end

endmodule

`default_nettype wire
